// File: rtl/page_walker_pkg.sv
// Shared definitions for the two-level page-table walker: state encoding,
// PTE field positions and the fault exception codes.
package page_walker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_L1    = 3'd1,
        ST_L2    = 3'd2,
        ST_FILL  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    localparam int PTE_VALID    = 0;
    localparam int PTE_USER     = 1;
    localparam int PTE_FRAME_LO = 12;
    localparam int PTE_FRAME_HI = 17;
    localparam int PTE_NEXT_LO  = 12;
    localparam int PTE_NEXT_HI  = 31;

    localparam logic [7:0] EXC_USER_FAULT = 8'h84;
    localparam logic [7:0] EXC_KERN_FAULT = 8'h85;

endpackage

// File: rtl/page_walker.sv
// Two-level hardware page-table walker: takes a TLB miss, reads the L1 and L2
// PTEs through a single request/ack memory port and either fills the TLB or faults.
module page_walker
    import page_walker_pkg::*;
#(
    parameter int PTBR_ALIGN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        abort,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [11:0] miss_pid,
    input  logic [31:0] miss_vaddr,
    input  logic        miss_kmode,
    input  logic [31:0] ptbr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        tlb_we,
    output logic [31:0] tlb_key,
    output logic [31:0] tlb_data,
    output logic        done,
    output logic        fault,
    output logic [7:0]  exc,
    output logic        busy
);

    localparam int BASE_W  = 32 - PTBR_ALIGN;
    localparam int NEXT_W  = PTE_NEXT_HI - PTE_NEXT_LO + 1;
    localparam int FRAME_W = PTE_FRAME_HI - PTE_FRAME_LO + 1;

    state_e               state_q, state_d;
    logic [11:0]          pid_q, pid_d;
    logic [19:0]          vpn_q, vpn_d;
    logic                 kmode_q, kmode_d;
    logic [BASE_W-1:0]    ptbr_q, ptbr_d;
    logic [NEXT_W-1:0]    next_q, next_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;

    // Address bits below the table alignment and the PTE flag bits we do not
    // interpret are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{ptbr[PTBR_ALIGN-1:0], miss_vaddr[11:0], mem_rdata[11:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pid_q   <= '0;
            vpn_q   <= '0;
            kmode_q <= 1'b0;
            ptbr_q  <= '0;
            next_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            vpn_q   <= vpn_d;
            kmode_q <= kmode_d;
            ptbr_q  <= ptbr_d;
            next_q  <= next_d;
            frame_q <= frame_d;
        end
    end

    // Everything advances only on enabled cycles; abort beats both a new
    // request and a memory ack arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        vpn_d   = vpn_q;
        kmode_d = kmode_q;
        ptbr_d  = ptbr_q;
        next_d  = next_q;
        frame_d = frame_q;
        if (clk_en) begin
            if (abort) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (miss_valid) begin
                            pid_d   = miss_pid;
                            vpn_d   = miss_vaddr[31:12];
                            kmode_d = miss_kmode;
                            ptbr_d  = ptbr[31:PTBR_ALIGN];
                            state_d = ST_L1;
                        end
                    end
                    ST_L1: begin
                        if (mem_ack) begin
                            if (!mem_rdata[PTE_VALID]) begin
                                state_d = ST_FAULT;
                            end else begin
                                next_d  = mem_rdata[PTE_NEXT_HI:PTE_NEXT_LO];
                                state_d = ST_L2;
                            end
                        end
                    end
                    ST_L2: begin
                        if (mem_ack) begin
                            if (!mem_rdata[PTE_VALID] || (!kmode_q && !mem_rdata[PTE_USER])) begin
                                state_d = ST_FAULT;
                            end else begin
                                frame_d = mem_rdata[PTE_FRAME_HI:PTE_FRAME_LO];
                                state_d = ST_FILL;
                            end
                        end
                    end
                    ST_FILL:  state_d = ST_IDLE;
                    ST_FAULT: state_d = ST_IDLE;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are decoded from registered state only, so they cannot move
    // while clk_en is low.
    always_comb begin
        miss_ready = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        tlb_we     = 1'b0;
        tlb_key    = '0;
        tlb_data   = '0;
        done       = 1'b0;
        fault      = 1'b0;
        exc        = 8'h00;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_L1: begin
                mem_req  = 1'b1;
                mem_addr = {ptbr_q, {PTBR_ALIGN{1'b0}}} | 32'({vpn_q[19:10], 2'b00});
            end
            ST_L2: begin
                mem_req  = 1'b1;
                mem_addr = {next_q, {PTE_NEXT_LO{1'b0}}} | 32'({vpn_q[9:0], 2'b00});
            end
            ST_FILL: begin
                tlb_we   = 1'b1;
                done     = 1'b1;
                tlb_key  = {pid_q, vpn_q};
                tlb_data = 32'(frame_q);
            end
            ST_FAULT: begin
                fault = 1'b1;
                exc   = kmode_q ? EXC_KERN_FAULT : EXC_USER_FAULT;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
